// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and constants (HALT state only with FETCH_MISALIGN_CHK_EN)
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
`ifdef FETCH_MISALIGN_CHK_EN
    , HALT
`endif
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - next-PC select and target alignment; misalign detect with FETCH_MISALIGN_CHK_EN
module fetch_pc_gen
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            pcsel,
  input  logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] pc_plus4,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic            misalign,
`endif
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] target_aligned;

  assign pc_plus4       = pc + 32'd4;
  assign target_aligned = {alu_out[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_CHK_EN
  // A misaligned target keeps its raw value so the faulting address is visible in pc.
  assign misalign = pcsel & alu_out[1];
  assign next_pc  = !pcsel ? pc_plus4 : (misalign ? alu_out : target_aligned);
`else
  logic unused_low_bits;
  assign unused_low_bits = ^alu_out[1:0];
  assign next_pc         = pcsel ? target_aligned : pc_plus4;
`endif

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage holding the PC; FETCH_MISALIGN_CHK_EN adds misalign/HALT
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            PCSel,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic            misalign,
`endif
  input  logic [XLEN-1:0] alu_out
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] next_pc;
  logic            accept;
`ifdef FETCH_MISALIGN_CHK_EN
  logic            target_misaligned;
`endif

  fetch_pc_gen u_pc_gen (
    .pc       (pc),
    .pcsel    (PCSel),
    .alu_out  (alu_out),
    .pc_plus4 (pc_plus4),
`ifdef FETCH_MISALIGN_CHK_EN
    .misalign (target_misaligned),
`endif
    .next_pc  (next_pc)
  );

  assign accept    = (state == HOLD) && instr_ready;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = REQ;
      REQ:  if (imem_gnt) state_next = WAIT;
      WAIT: if (imem_rvalid) state_next = HOLD;
      HOLD: if (instr_ready) begin
`ifdef FETCH_MISALIGN_CHK_EN
        state_next = target_misaligned ? HALT : REQ;
`else
        state_next = REQ;
`endif
      end
`ifdef FETCH_MISALIGN_CHK_EN
      HALT: state_next = HALT;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      REQ:     imem_req    = 1'b1;
      HOLD:    instr_valid = 1'b1;
      default: ;
    endcase
  end

  // Responses are captured only in WAIT, so a late rvalid after reset falls on the floor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      instr <= NOP_INSTR;
    end else begin
      if (state == WAIT && imem_rvalid) instr <= imem_rdata;
      if (accept) pc <= next_pc;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            misalign <= 1'b0;
    else if (accept && target_misaligned) misalign <= 1'b1;
  end
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle RISC-V core. It sits directly upstream of the instruction decoder/controller and holds the architectural PC. It fetches one 32-bit instruction at a time from instruction memory over a req/gnt/rvalid handshake, presents it with the current PC to decode/execute, and on consumption selects the next PC: PC+4, or the branch/jump target when `PCSel`=1.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset; must be 4-byte aligned.
- `clk`  in  1  sole clock, rising edge. One clock; reset is asynchronous and active-high.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request; held until granted.
- `imem_addr`  out  32  fetch address (equals `pc`).
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  held instruction, feeds controller `instr`.
- `instr_valid`  out  1  `instr` and `pc` are valid.
- `instr_ready`  in  1  execute retires the held instruction this cycle.
- `pc`  out  32  PC of the held instruction.
- `pc_plus4`  out  32  `pc`+4, used for the WBSel=2 writeback.
- `PCSel`  in  1  from controller: 1 selects `alu_out` as next PC.
- `alu_out`  in  32  branch/jump target.
- `misalign`  out  1  sticky misaligned-target flag; present only with the macro.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, HALT (HALT only with the macro).
- IDLE: entered during reset; moves to REQ on the first clock after `rst` deasserts.
- REQ: `imem_req`=1 and `imem_addr`=`pc`. When `imem_gnt`=1 → WAIT. Otherwise stay in REQ with the address stable.
- WAIT: when `imem_rvalid`=1, load `instr`←`imem_rdata` → HOLD. `imem_rvalid` outside WAIT is ignored.
- HOLD: `instr_valid`=1. `instr` and `pc` stay stable until `instr_ready`=1.
- On `instr_ready`=1 in HOLD, update `pc` and go to REQ:
  - `PCSel`=0: `pc`←`pc`+4.
  - `PCSel`=1: `pc`←{`alu_out`[31:2],2'b00}.
- `instr_ready` outside HOLD is ignored.
- Only one request may be outstanding; no prefetch.
- Arithmetic is 32-bit modulo; `pc`+4 wraps 32'hFFFF_FFFC→32'h0000_0000 with no flag.
- `pc_plus4` is combinational from `pc`.
- `PCSel` and `alu_out` are sampled only on the accepting edge.
- Reset mid-operation: any outstanding grant/response is discarded. The FSM returns to IDLE, and a late `imem_rvalid` is ignored.
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4, `instr`=32'h0000_0013 (NOP), `instr_valid`=0, `misalign`=0, state IDLE.

## Timing
- `imem_req`, `instr_valid` and `imem_addr` are decoded from registered state/PC; there are no input→output combinational paths except `pc_plus4`.
- `imem_gnt` may be asserted in the same cycle `imem_req` rises.
- `imem_rvalid` arrives no earlier than the cycle after `imem_gnt`.
- Best-case throughput: 3 cycles per instruction (REQ+gnt, WAIT+rvalid, HOLD+ready).
- `instr_valid` rises the cycle after `imem_rvalid`.
- After an accept, `imem_req` is high in the following cycle.

## Configuration
- Macro: `FETCH_MISALIGN_CHK_EN`.
- Defined:
  - On accept with `PCSel`=1 and `alu_out`[1]=1, set `misalign`=1 (sticky) and enter HALT.
  - HALT issues no requests and holds `instr_valid`=0 until reset.
  - `pc` is loaded with the raw misaligned target for debug visibility.
- Undefined:
  - No `misalign` port and no HALT state.
  - Target bits [1:0] are silently forced to 00.

## Structure
- Shared package `riscv_pkg`:
  - `fetch_state_t` enum.
  - `NOP_INSTR` = 32'h0000_0013.
  - `XLEN` = 32.
- One sub-module, `fetch_pc_gen`: combinational next-PC select and target alignment/misalign detect, instantiated by `fetch_unit`.

## Test plan
- Reset release, `RESET_PC`=32'h100, memory grants immediately and returns 32'h00500093 one cycle later → `imem_addr`=32'h100; `instr`=32'h00500093 with `instr_valid`=1 at cycle 3; `pc_plus4`=32'h104.
- Sequential flow, `instr_ready` always 1, `PCSel`=0 → fetch addresses 32'h100, 32'h104, 32'h108, one every 3 cycles.
- Taken branch: accept with `PCSel`=1, `alu_out`=32'h0000_0200 → next `imem_addr`=32'h200.
- Stalls: `imem_gnt` low for 4 cycles and `instr_ready` low for 5 cycles → address and `instr` stay stable, with no duplicate request.
- Reset asserted in WAIT, then `imem_rvalid`=1 after release → response ignored; `instr`=32'h0000_0013; refetch from `RESET_PC`.
- With `FETCH_MISALIGN_CHK_EN`, accept with `PCSel`=1, `alu_out`=32'h0000_0102 → `misalign`=1, `imem_req` stays 0. Without the macro → next `imem_addr`=32'h100.
